// File: rtl/stb_fwd_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stb_fwd_buffer: in-order store buffer with per-byte store-to-load          |
// | forwarding and dcache drain FSM. Optional macro: STB_MERGE_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stb_fwd_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          lsu_req_i,
   input  logic                          lsu_w_en_i,
   input  logic [ADDR_WIDTH-1:0]         lsu_addr_i,
   input  logic [DATA_WIDTH-1:0]         lsu_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]       lsu_sel_byte_i,
   output logic                          lsu_ack_o,
   output logic [DATA_WIDTH-1:0]         lsu_rdata_o,
   output logic                          lsu_stall_o,
   input  logic                          flush_i,
   output logic                          dcache_req_o,
   output logic                          dcache_w_en_o,
   output logic [ADDR_WIDTH-1:0]         dcache_addr_o,
   output logic [DATA_WIDTH-1:0]         dcache_wdata_o,
   output logic [DATA_WIDTH/8-1:0]       dcache_sel_byte_o,
   input  logic                          dcache_ack_i,
   input  logic [DATA_WIDTH-1:0]         dcache_rdata_i,
   output logic                          stb_empty_o,
   output logic [$clog2(DEPTH+1)-1:0]    stb_count_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int WA    = ADDR_WIDTH - OFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   state_t                r_state;
   logic [WA-1:0]         r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [BYTES-1:0]      r_mask [DEPTH];
   logic [DEPTH-1:0]      r_valid;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;
   logic                  r_lsu_ack;
   logic [DATA_WIDTH-1:0] r_lsu_rdata;
   logic                  r_dc_req;
   logic                  r_dc_wen;
   logic [ADDR_WIDTH-1:0] r_dc_addr;
   logic [DATA_WIDTH-1:0] r_dc_wdata;
   logic [BYTES-1:0]      r_dc_sel;

   logic [WA-1:0]         w_lwa;
   logic                  w_full;
   logic [PW-1:0]         w_idx;
   logic [BYTES-1:0]      w_cover;
   logic [DATA_WIDTH-1:0] w_fwd_data;
   logic                  w_hit_any;
   logic                  w_full_hit;
   logic                  w_ld;
   logic                  w_ld_hit;
   logic                  w_ld_miss;
   logic                  w_merge;
   logic                  w_st_acc;
   logic                  w_enq;
   logic                  w_drain_ack;

   assign w_lwa       = lsu_addr_i[ADDR_WIDTH-1:OFF];
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_drain_ack = (r_state == S_DRAIN) & dcache_ack_i;

   // Walk oldest to youngest so the youngest matching byte wins.
   always_comb begin
      w_idx      = '0;
      w_cover    = '0;
      w_fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PW'(k);
         if (r_valid[w_idx] && (r_addr[w_idx] == w_lwa)) begin
            for (int b = 0; b < BYTES; b++) begin
               if (r_mask[w_idx][b] && lsu_sel_byte_i[b]) begin
                  w_cover[b]           = 1'b1;
                  w_fwd_data[b*8 +: 8] = r_data[w_idx][b*8 +: 8];
               end
            end
         end
      end
   end

   assign w_hit_any  = |w_cover;
   assign w_full_hit = w_hit_any & ((lsu_sel_byte_i & ~w_cover) == '0);
   assign w_ld       = lsu_req_i & ~lsu_w_en_i & ~r_lsu_ack;
   assign w_ld_hit   = w_ld & w_full_hit;
   assign w_ld_miss  = w_ld & ~w_hit_any;

`ifdef STB_MERGE_EN
   logic [PW-1:0]         w_yidx;
   logic [DATA_WIDTH-1:0] w_merge_data;

   // The youngest entry is off limits once it may be the head captured for drain.
   assign w_yidx  = r_tail - PW'(1);
   assign w_merge = lsu_req_i & lsu_w_en_i & (r_count != '0) & r_valid[w_yidx]
                    & (r_addr[w_yidx] == w_lwa)
                    & ~((w_yidx == r_head) & (r_state != S_LOAD));

   always_comb begin
      w_merge_data = r_data[w_yidx];
      for (int b = 0; b < BYTES; b++) begin
         if (lsu_sel_byte_i[b]) w_merge_data[b*8 +: 8] = lsu_wdata_i[b*8 +: 8];
      end
   end
`else
   assign w_merge = 1'b0;
`endif

   assign w_st_acc = lsu_req_i & lsu_w_en_i & ~flush_i & ~r_lsu_ack & (~w_full | w_merge);
   assign w_enq    = w_st_acc & ~w_merge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_mask[i] <= '0;
         end
      end else begin
         if (w_enq) begin
            r_addr[r_tail]  <= w_lwa;
            r_data[r_tail]  <= lsu_wdata_i;
            r_mask[r_tail]  <= lsu_sel_byte_i;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PW'(1);
         end
`ifdef STB_MERGE_EN
         if (w_st_acc && w_merge) begin
            r_data[w_yidx] <= w_merge_data;
            r_mask[w_yidx] <= r_mask[w_yidx] | lsu_sel_byte_i;
         end
`endif
         if (w_drain_ack) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         r_count <= r_count + CW'(w_enq) - CW'(w_drain_ack);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_lsu_ack   <= 1'b0;
         r_lsu_rdata <= '0;
         r_dc_req    <= 1'b0;
         r_dc_wen    <= 1'b0;
         r_dc_addr   <= '0;
         r_dc_wdata  <= '0;
         r_dc_sel    <= '0;
      end else begin
         r_lsu_ack <= w_st_acc | w_ld_hit | ((r_state == S_LOAD) & dcache_ack_i);
         if (w_ld_hit) begin
            r_lsu_rdata <= w_fwd_data;
         end else if ((r_state == S_LOAD) && dcache_ack_i) begin
            r_lsu_rdata <= dcache_rdata_i;
         end
         case (r_state)
            S_IDLE: begin
               if (w_ld_miss && !w_full) begin
                  r_state    <= S_LOAD;
                  r_dc_req   <= 1'b1;
                  r_dc_wen   <= 1'b0;
                  r_dc_addr  <= lsu_addr_i;
                  r_dc_wdata <= '0;
                  r_dc_sel   <= lsu_sel_byte_i;
               end else if (r_count != '0) begin
                  r_state    <= S_DRAIN;
                  r_dc_req   <= 1'b1;
                  r_dc_wen   <= 1'b1;
                  r_dc_addr  <= {r_addr[r_head], {OFF{1'b0}}};
                  r_dc_wdata <= r_data[r_head];
                  r_dc_sel   <= r_mask[r_head];
               end
            end
            S_DRAIN, S_LOAD: begin
               if (dcache_ack_i) begin
                  r_state  <= S_IDLE;
                  r_dc_req <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_dc_req <= 1'b0;
            end
         endcase
      end
   end

   assign lsu_ack_o         = r_lsu_ack;
   assign lsu_rdata_o       = r_lsu_rdata;
   assign lsu_stall_o       = lsu_req_i & ~r_lsu_ack;
   assign dcache_req_o      = r_dc_req;
   assign dcache_w_en_o     = r_dc_wen;
   assign dcache_addr_o     = r_dc_addr;
   assign dcache_wdata_o    = r_dc_wdata;
   assign dcache_sel_byte_o = r_dc_sel;
   assign stb_empty_o       = (r_count == '0) & (r_state == S_IDLE);
   assign stb_count_o       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_stb_fwd_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stb_fwd_buffer: scoreboard bench for stb_fwd_buffer (DEPTH 4, 32 bit).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_stb_fwd_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lsu_req_i = 1'b0;
   logic        lsu_w_en_i = 1'b0;
   logic [31:0] lsu_addr_i = '0;
   logic [31:0] lsu_wdata_i = '0;
   logic [3:0]  lsu_sel_byte_i = '0;
   logic        lsu_ack_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_stall_o;
   logic        flush_i = 1'b0;
   logic        dcache_req_o;
   logic        dcache_w_en_o;
   logic [31:0] dcache_addr_o;
   logic [31:0] dcache_wdata_o;
   logic [3:0]  dcache_sel_byte_o;
   logic        dcache_ack_i = 1'b0;
   logic [31:0] dcache_rdata_i = '0;
   logic        stb_empty_o;
   logic [2:0]  stb_count_o;

   stb_fwd_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_req_i(lsu_req_i), .lsu_w_en_i(lsu_w_en_i), .lsu_addr_i(lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_sel_byte_i(lsu_sel_byte_i),
      .lsu_ack_o(lsu_ack_o), .lsu_rdata_o(lsu_rdata_o), .lsu_stall_o(lsu_stall_o),
      .flush_i(flush_i),
      .dcache_req_o(dcache_req_o), .dcache_w_en_o(dcache_w_en_o),
      .dcache_addr_o(dcache_addr_o), .dcache_wdata_o(dcache_wdata_o),
      .dcache_sel_byte_o(dcache_sel_byte_o), .dcache_ack_i(dcache_ack_i),
      .dcache_rdata_i(dcache_rdata_i),
      .stb_empty_o(stb_empty_o), .stb_count_o(stb_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } drain_t;

   drain_t      exp_drain_q[$];
   logic [31:0] exp_rd_q[$];
   drain_t      dc_exp;
   int          checks = 0;
   int          errors = 0;
   int          dc_credit = 1000000;
   int          dc_wait = 0;
   int          dc_drains = 0;
   int          dc_loads = 0;
   int          dc_drains_at_load = 0;
   logic [31:0] dc_load_data = '0;
   logic [31:0] exp_ld_addr = '0;

   // dcache model: acks on the third cycle of a request while credit remains
   always @(negedge clk) begin
      dcache_ack_i = 1'b0;
      if (rst_n && dcache_req_o) begin
         if (dc_wait >= 2 && dc_credit > 0) begin
            dc_credit--;
            dc_wait      = 0;
            dcache_ack_i = 1'b1;
            checks++;
            if (dcache_w_en_o) begin
               if (exp_drain_q.size() == 0) begin
                  errors++;
                  $display("FAIL drain_unexpected got=%h/%h/%h", dcache_addr_o, dcache_wdata_o, dcache_sel_byte_o);
               end else begin
                  dc_exp = exp_drain_q.pop_front();
                  if ({dcache_addr_o, dcache_wdata_o, dcache_sel_byte_o} !== dc_exp) begin
                     errors++;
                     $display("FAIL drain_entry got=%h/%h/%h exp=%h/%h/%h", dcache_addr_o, dcache_wdata_o,
                              dcache_sel_byte_o, dc_exp.a, dc_exp.d, dc_exp.s);
                  end
               end
               dc_drains++;
            end else begin
               dcache_rdata_i    = dc_load_data;
               dc_loads++;
               dc_drains_at_load = dc_drains;
               if (dcache_addr_o !== exp_ld_addr) begin
                  errors++;
                  $display("FAIL load_addr got=%h exp=%h", dcache_addr_o, exp_ld_addr);
               end
            end
         end else if (dc_wait < 2) begin
            dc_wait++;
         end
      end else begin
         dc_wait = 0;
      end
   end

   task automatic store_start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit push);
      @(negedge clk);
      lsu_req_i = 1'b1; lsu_w_en_i = 1'b1; lsu_addr_i = a; lsu_wdata_i = d; lsu_sel_byte_i = s;
      if (push) exp_drain_q.push_back({a & 32'hFFFF_FFFC, d, s});
   endtask

   task automatic load_start(input logic [31:0] a, input logic [3:0] s, input logic [31:0] exp);
      @(negedge clk);
      lsu_req_i = 1'b1; lsu_w_en_i = 1'b0; lsu_addr_i = a; lsu_wdata_i = '0; lsu_sel_byte_i = s;
      exp_rd_q.push_back(exp);
   endtask

   task automatic wait_ack(input int budget, output bit got, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (lsu_ack_o !== 1'b1 && lat < budget);
      got = (lsu_ack_o === 1'b1);
      lsu_req_i = 1'b0;
   endtask

   task automatic wait_drains(input int target, output bit ok);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (dc_drains < target && n < 200);
      ok = (dc_drains >= target);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({stb_empty_o, stb_count_o, lsu_ack_o, lsu_stall_o, dcache_req_o, dcache_w_en_o} !== 8'b1_000_0000) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=%b", {stb_empty_o, stb_count_o, lsu_ack_o, lsu_stall_o, dcache_req_o, dcache_w_en_o}, 8'b1_000_0000);
      end
      checks++;
      if ({lsu_rdata_o, dcache_addr_o, dcache_wdata_o, dcache_sel_byte_o} !== '0) begin
         errors++;
         $display("FAIL reset_data got=%h exp=0", {lsu_rdata_o, dcache_addr_o, dcache_wdata_o, dcache_sel_byte_o});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (stb_empty_o !== 1'b1 || dcache_req_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got=%b%b exp=10", stb_empty_o, dcache_req_o);
      end
   endtask

   task automatic test_drain_order();
      bit got; int lat; bit ok; int base = dc_drains;
      store_start(32'h100, 32'h1122_3344, 4'b1111, 1'b1);
      wait_ack(10, got, lat);
      checks++;
      if (got !== 1'b1 || lat != 1 || stb_count_o !== 3'd1) begin
         errors++;
         $display("FAIL store1_ack got=%b lat=%0d cnt=%0d exp=1 lat=1 cnt=1", got, lat, stb_count_o);
      end
      store_start(32'h104, 32'h5566_7788, 4'b1111, 1'b1);
      wait_ack(10, got, lat);
      checks++;
      if (got !== 1'b1 || stb_count_o !== 3'd2) begin
         errors++;
         $display("FAIL store2_ack got=%b cnt=%0d exp=1 cnt=2", got, stb_count_o);
      end
      wait_drains(base + 1, ok);
      checks++;
      if (!ok || stb_count_o !== 3'd1) begin
         errors++;
         $display("FAIL drain_count1 got=%0d exp=1", stb_count_o);
      end
      wait_drains(base + 2, ok);
      checks++;
      if (!ok || stb_count_o !== 3'd0 || stb_empty_o !== 1'b1) begin
         errors++;
         $display("FAIL drain_count0 got=%0d/%b exp=0/1", stb_count_o, stb_empty_o);
      end
   endtask

   task automatic test_forward();
      bit got; int lat; bit ok; int base = dc_drains; int loads = dc_loads;
      logic [31:0] exp;
      dc_credit = 0;
      store_start(32'h200, 32'hAABB_CCDD, 4'b1111, 1'b1);
      wait_ack(10, got, lat);
      store_start(32'h200, 32'h0000_00EE, 4'b0001, 1'b1);
      wait_ack(10, got, lat);
      load_start(32'h200, 4'b1111, 32'hAABB_CCEE);
      wait_ack(10, got, lat);
      exp = exp_rd_q.pop_front();
      checks++;
      if (got !== 1'b1 || lat != 1 || lsu_rdata_o !== exp) begin
         errors++;
         $display("FAIL fwd_full got=%h lat=%0d exp=%h lat=1", lsu_rdata_o, lat, exp);
      end
      load_start(32'h202, 4'b0110, 32'h00BB_CC00);
      wait_ack(10, got, lat);
      exp = exp_rd_q.pop_front();
      checks++;
      if (got !== 1'b1 || lat != 1 || lsu_rdata_o !== exp) begin
         errors++;
         $display("FAIL fwd_sub got=%h lat=%0d exp=%h lat=1", lsu_rdata_o, lat, exp);
      end
      checks++;
      if (dc_loads != loads || stb_count_o !== 3'd2) begin
         errors++;
         $display("FAIL fwd_no_dc_load got=%0d/%0d exp=%0d/2", dc_loads, stb_count_o, loads);
      end
      dc_credit = 1000000;
      wait_drains(base + 2, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fwd_drain got=%0d exp=%0d", dc_drains, base + 2);
      end
   endtask

   task automatic test_partial();
      bit got; int lat; int base = dc_drains; int loads = dc_loads;
      logic [31:0] exp;
      dc_load_data = 32'h1234_5678;
      exp_ld_addr  = 32'h300;
      store_start(32'h300, 32'hCAFE_BEEF, 4'b0011, 1'b1);
      wait_ack(10, got, lat);
      load_start(32'h300, 4'b1111, 32'h1234_5678);
      repeat (2) @(negedge clk);
      checks++;
      if (lsu_stall_o !== 1'b1 || lsu_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL partial_stall got=%b%b exp=10", lsu_stall_o, lsu_ack_o);
      end
      wait_ack(60, got, lat);
      exp = exp_rd_q.pop_front();
      checks++;
      if (got !== 1'b1 || lsu_rdata_o !== exp) begin
         errors++;
         $display("FAIL partial_rdata got=%h exp=%h", lsu_rdata_o, exp);
      end
      checks++;
      if (dc_loads != loads + 1 || dc_drains_at_load != base + 1) begin
         errors++;
         $display("FAIL partial_order got=%0d/%0d exp=%0d/%0d", dc_loads, dc_drains_at_load, loads + 1, base + 1);
      end
   endtask

   task automatic test_full_wrap();
      bit got; int lat; bit ok; int base = dc_drains;
      dc_credit = 0;
      for (int i = 0; i < 4; i++) begin
         store_start(32'h500 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b1111, 1'b1);
         wait_ack(10, got, lat);
      end
      store_start(32'h510, 32'hA000_0004, 4'b1111, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (lsu_ack_o !== 1'b0 || lsu_stall_o !== 1'b1 || stb_count_o !== 3'd4) begin
         errors++;
         $display("FAIL full_stall got=%b%b cnt=%0d exp=01 cnt=4", lsu_ack_o, lsu_stall_o, stb_count_o);
      end
      dc_credit = 1;
      wait_ack(30, got, lat);
      checks++;
      if (got !== 1'b1 || stb_count_o !== 3'd4) begin
         errors++;
         $display("FAIL full_accept got=%b cnt=%0d exp=1 cnt=4", got, stb_count_o);
      end
      dc_credit = 1000000;
      wait_drains(base + 5, ok);
      checks++;
      if (!ok || stb_count_o !== 3'd0) begin
         errors++;
         $display("FAIL wrap_drain got=%0d/%0d exp=%0d/0", dc_drains, stb_count_o, base + 5);
      end
   endtask

   task automatic test_flush();
      bit got; int lat; bit ok; int n = 0; int base = dc_drains;
      dc_credit = 0;
      for (int i = 0; i < 3; i++) begin
         store_start(32'h600 + 32'(i * 4), 32'hF000_0000 + 32'(i), 4'b1111, 1'b1);
         wait_ack(10, got, lat);
      end
      @(negedge clk);
      flush_i = 1'b1;
      store_start(32'h60C, 32'hF000_0003, 4'b1111, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (lsu_ack_o !== 1'b0 || lsu_stall_o !== 1'b1 || stb_count_o !== 3'd3) begin
         errors++;
         $display("FAIL flush_stall got=%b%b cnt=%0d exp=01 cnt=3", lsu_ack_o, lsu_stall_o, stb_count_o);
      end
      dc_credit = 1000000;
      while (stb_empty_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (stb_empty_o !== 1'b1 || dc_drains != base + 3 || lsu_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty got=%b/%0d exp=1/%0d", stb_empty_o, dc_drains, base + 3);
      end
      flush_i = 1'b0;
      wait_ack(10, got, lat);
      wait_drains(base + 4, ok);
      checks++;
      if (got !== 1'b1 || !ok || stb_count_o !== 3'd0) begin
         errors++;
         $display("FAIL flush_resume got=%b/%0d exp=1/%0d", got, dc_drains, base + 4);
      end
   endtask

`ifdef STB_MERGE_EN
   task automatic test_merge();
      bit got; int lat; bit ok; int base = dc_drains;
      dc_credit = 0;
      store_start(32'h3F0, 32'h0102_0304, 4'b1111, 1'b1);
      wait_ack(10, got, lat);
      store_start(32'h400, 32'h0000_00A1, 4'b0001, 1'b0);
      wait_ack(10, got, lat);
      store_start(32'h400, 32'h00B2_0000, 4'b0100, 1'b0);
      wait_ack(10, got, lat);
      exp_drain_q.push_back({32'h400, 32'h00B2_00A1, 4'b0101});
      checks++;
      if (got !== 1'b1 || stb_count_o !== 3'd2) begin
         errors++;
         $display("FAIL merge_count got=%0d exp=2", stb_count_o);
      end
      dc_credit = 1000000;
      wait_drains(base + 2, ok);
      checks++;
      if (!ok || stb_count_o !== 3'd0) begin
         errors++;
         $display("FAIL merge_drain got=%0d exp=%0d", dc_drains, base + 2);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_drain_order();
      test_forward();
      test_partial();
      test_full_wrap();
      test_flush();
`ifdef STB_MERGE_EN
      test_merge();
`endif
      repeat (4) @(negedge clk);
      checks++;
      if (exp_drain_q.size() != 0 || exp_rd_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got=%0d/%0d exp=0/0", exp_drain_q.size(), exp_rd_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
